// File: rtl/mul_ctrl_pkg.sv
// Shared encodings and row-count bounds for the multiplier row sequencer.
// State values are visible on the debug port, so they are fixed here.
package mul_ctrl_pkg;

    localparam int ROWS_DEFAULT = 32;
    localparam int ROWS_MIN     = 2;
    localparam int ROWS_MAX     = 128;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ZERO_ROW  = 3'd1,
        S_WRITE_NEW = 3'd2,
        S_READ_PREV = 3'd3,
        S_CLEAR     = 3'd4,
        S_DONE      = 3'd5
    } state_e;

    // A requested row count larger than the CA_RAM depth saturates at the depth.
    function automatic int clamp_rows(input int n, input int rows);
        return (n > rows) ? rows : n;
    endfunction

endpackage

// File: rtl/mul_row_sequencer_if.sv
// Control/status bundle between the multiplier controller and the row sequencer.
// master drives start/n_rows/mode/stall; slave (the sequencer) drives the CA_RAM side.
interface mul_row_sequencer_if #(
    parameter int ADDR_W = 5
);
    logic              start;
    logic [ADDR_W:0]   n_rows;
    logic              mode;
    logic              stall;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              in_req;
    logic [ADDR_W-1:0] row;
    logic [2:0]        state;
    logic              busy;
    logic              done;

    modport master (
        output start, n_rows, mode, stall,
        input  addr, we, in_req, row, state, busy, done
    );

    modport slave (
        input  start, n_rows, mode, stall,
        output addr, we, in_req, row, state, busy, done
    );

endinterface

// File: rtl/mul_row_sequencer.sv
// Walks the CA_RAM partial-product rows for one multiplication: writes each new row,
// optionally re-reads all earlier rows, and pulses done when the last row is cleared.
module mul_row_sequencer
    import mul_ctrl_pkg::*;
#(
    parameter int ROWS   = ROWS_DEFAULT,
    parameter int ADDR_W = $clog2(ROWS)
) (
    input  logic               clk,
    input  logic               rst,
    mul_row_sequencer_if.slave bus
);

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [ADDR_W:0]   cnt_t;

    state_e state_q, state_d;
    addr_t  row_q, row_d;
    addr_t  addr_q, addr_d;
    cnt_t   count_q, count_d;
    logic   mode_q, mode_d;

    logic   last_row;
    addr_t  addr_out;
    logic   we_raw;
    logic   in_req_raw;
    logic   done_raw;

    assign last_row = ({1'b0, row_q} == (count_q - cnt_t'(1)));

    // Reset wins over stall; otherwise stall freezes every register so the cycle replays.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            addr_q  <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
        end else if (!bus.stall) begin
            state_q <= state_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        addr_d     = addr_q;
        count_d    = count_q;
        mode_d     = mode_q;
        addr_out   = '0;
        we_raw     = 1'b0;
        in_req_raw = 1'b0;
        done_raw   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.n_rows != '0)) begin
                    count_d = cnt_t'(clamp_rows(int'(bus.n_rows), ROWS));
                    mode_d  = bus.mode;
                    row_d   = '0;
                    addr_d  = '0;
                    state_d = S_ZERO_ROW;
                end
            end
            S_ZERO_ROW: begin
                we_raw     = 1'b1;
                in_req_raw = 1'b1;
                if (count_q == cnt_t'(1)) begin
                    state_d = S_DONE;
                end else begin
                    row_d   = addr_t'(1);
                    state_d = S_WRITE_NEW;
                end
            end
            S_WRITE_NEW: begin
                addr_out = row_q;
                we_raw   = 1'b1;
                // row_q is at least 1 here, so row_q-1 cannot underflow.
                if (!mode_q) begin
                    addr_d  = row_q - addr_t'(1);
                    state_d = S_READ_PREV;
                end else begin
                    state_d = S_CLEAR;
                end
            end
            S_READ_PREV: begin
                addr_out = addr_q;
                if (addr_q == '0) begin
                    in_req_raw = 1'b1;
                    state_d    = S_CLEAR;
                end else begin
                    addr_d = addr_q - addr_t'(1);
                end
            end
            S_CLEAR: begin
                in_req_raw = mode_q;
                addr_d     = '0;
                if (last_row) begin
                    state_d = S_DONE;
                end else begin
                    row_d   = row_q + addr_t'(1);
                    state_d = S_WRITE_NEW;
                end
            end
            S_DONE: begin
                done_raw = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.addr   = addr_out;
    assign bus.we     = we_raw & ~bus.stall;
    assign bus.in_req = in_req_raw & ~bus.stall;
    assign bus.done   = done_raw & ~bus.stall;
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.row    = row_q;
    assign bus.state  = state_q;

endmodule

// File: tb/tb_mul_row_sequencer.sv
// Directed bench for mul_row_sequencer (ROWS=8): a trace-list model checked every cycle
// plus literal expectations for the documented waveforms.
module tb_mul_row_sequencer;
    import mul_ctrl_pkg::*;

    localparam int ROWS = 8;
    localparam int AW   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_row_sequencer_if #(.ADDR_W(AW)) bus ();

    mul_row_sequencer #(.ROWS(ROWS), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [2:0]    st;
        logic [AW-1:0] addr;
        logic [AW-1:0] row;
        logic          we;
        logic          in_req;
        logic          done;
    } exp_t;
    typedef exp_t exp_q_t[$];

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    exp_t          expq[$];
    exp_t          mon_e;
    logic [12:0]   act_v;
    logic [12:0]   req_v;
    bit            was_idle;
    logic [AW-1:0] idle_row = '0;

    int tr_state[64];
    int tr_addr[64];
    int tr_we[64];
    int tr_in[64];
    int tr_busy[64];
    int tr_done[64];
    int last_wr;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input state_e s, input int a, input int r,
                                input bit w, input bit i, input bit d);
        exp_t e;
        e.st     = s;
        e.addr   = AW'(a);
        e.row    = AW'(r);
        e.we     = w;
        e.in_req = i;
        e.done   = d;
        return e;
    endfunction

    // Expected per-cycle outputs of one whole operation, listed row by row.
    function automatic exp_q_t build_trace(input int n, input bit m);
        exp_q_t q;
        int nc;
        nc = (n > ROWS) ? ROWS : n;
        q.push_back(mk(S_ZERO_ROW, 0, 0, 1'b1, 1'b1, 1'b0));
        for (int r = 1; r < nc; r++) begin
            q.push_back(mk(S_WRITE_NEW, r, r, 1'b1, 1'b0, 1'b0));
            if (!m) begin
                for (int a = r - 1; a >= 0; a--)
                    q.push_back(mk(S_READ_PREV, a, r, 1'b0, (a == 0), 1'b0));
            end
            q.push_back(mk(S_CLEAR, 0, r, 1'b0, m, 1'b0));
        end
        q.push_back(mk(S_DONE, 0, nc - 1, 1'b0, 1'b0, 1'b1));
        return q;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            act_v    = {bus.state, bus.addr, bus.row, bus.busy, bus.we, bus.in_req, bus.done};
            was_idle = (expq.size() == 0);
            if (was_idle) begin
                req_v = {3'd0, {AW{1'b0}}, idle_row, 4'b0000};
            end else begin
                mon_e = expq[0];
                req_v = {mon_e.st, mon_e.addr, mon_e.row, 1'b1,
                         mon_e.we & ~bus.stall, mon_e.in_req & ~bus.stall, mon_e.done & ~bus.stall};
                if (!bus.stall) begin
                    if (mon_e.done) idle_row = mon_e.row;
                    void'(expq.pop_front());
                end
            end
            n_checks++;
            if (act_v != req_v) begin
                n_errors++;
                $display("FAIL cycle_model t=%0t {state,addr,row,busy,we,in_req,done}: got %b, expected %b",
                         $time, act_v, req_v);
            end
            if (rst) begin
                expq.delete();
                idle_row = '0;
            end else if (was_idle && !bus.stall && bus.start && (bus.n_rows != '0)) begin
                expq = build_trace(int'(bus.n_rows), bus.mode);
            end
        end
    end

    // Called just after a rising edge; the current cycle becomes cycle 0 of the run.
    task automatic run_op(input int n, input bit m, input int st_lo, input int st_hi,
                          input int rst_at, input int late_at, input int exp_done);
        int done_at;
        done_at      = -1;
        last_wr      = -1;
        bus.start    = 1'b1;
        bus.n_rows   = (AW+1)'(n);
        bus.mode     = m;
        bus.stall    = 1'b0;
        rst          = 1'b0;
        for (int k = 1; k <= 60 && done_at < 0; k++) begin
            @(posedge clk);
            #1;
            bus.start  = (k == late_at);
            bus.n_rows = (AW+1)'(2);
            bus.mode   = ~m;
            bus.stall  = (k >= st_lo && k <= st_hi);
            rst        = (k == rst_at);
            @(negedge clk);
            tr_state[k] = int'(bus.state);
            tr_addr[k]  = int'(bus.addr);
            tr_we[k]    = int'(bus.we);
            tr_in[k]    = int'(bus.in_req);
            tr_busy[k]  = int'(bus.busy);
            tr_done[k]  = int'(bus.done);
            if (bus.we) last_wr = int'(bus.addr);
            if (bus.done) done_at = k;
        end
        $display("run n_rows=%0d mode=%0d stall=[%0d..%0d] rst_at=%0d late_start=%0d done_at=%0d",
                 n, m, st_lo, st_hi, rst_at, late_at, done_at);
        chk($sformatf("done_cycle_n%0d_m%0d", n, m), done_at, exp_done);
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.stall  = 1'b0;
        bus.n_rows = '0;
        bus.mode   = 1'b0;
        rst        = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_q_t tq;
        int exp_addr[15];
        int exp_st6[7];

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.n_rows = '0;
        bus.mode   = 1'b0;
        bus.stall  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.stall = 1'b0;
        mon_en    = 1'b1;
        @(negedge clk);
        chk("reset_state", int'(bus.state), 0);
        chk("reset_busy",  int'(bus.busy), 0);
        chk("reset_addr",  int'(bus.addr), 0);
        @(posedge clk);
        #1;

        tq = build_trace(4, 1'b0);
        chk("model_len_n4_m0", tq.size(), 14);
        tq = build_trace(3, 1'b1);
        chk("model_len_n3_m1", tq.size(), 6);
        tq = build_trace(15, 1'b0);
        chk("model_len_n15_clamped", tq.size(), 44);

        // N=4 accumulate, with an ignored start at cycle 3.
        run_op(4, 1'b0, 0, 0, 0, 3, 14);
        exp_addr = '{0, 0, 1, 0, 0, 2, 1, 0, 0, 3, 2, 1, 0, 0, 0};
        for (int k = 1; k <= 14; k++) begin
            chk($sformatf("n4_addr_c%0d", k), tr_addr[k], exp_addr[k]);
            chk($sformatf("n4_we_c%0d", k), tr_we[k], int'(k == 1 || k == 2 || k == 5 || k == 9));
            chk($sformatf("n4_in_req_c%0d", k), tr_in[k], int'(k == 1 || k == 3 || k == 7 || k == 12));
        end

        // N=3 bypass.
        run_op(3, 1'b1, 0, 0, 0, 0, 6);
        exp_st6 = '{0, 1, 2, 4, 2, 4, 5};
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("n3_state_c%0d", k), tr_state[k], exp_st6[k]);
            chk($sformatf("n3_in_req_c%0d", k), tr_in[k], int'(k == 1 || k == 3 || k == 5));
        end

        // N=1 and N=0.
        run_op(1, 1'b0, 0, 0, 0, 0, 2);
        chk("n1_state_c1", tr_state[1], 1);
        run_op(0, 1'b0, 0, 0, 0, 0, -1);
        chk("n0_busy_c1", tr_busy[1], 0);
        chk("n0_busy_c5", tr_busy[5], 0);

        // Stall during cycles 6-8 of an N=4 accumulate run.
        run_op(4, 1'b0, 6, 8, 0, 0, 17);
        for (int k = 6; k <= 9; k++) begin
            chk($sformatf("stall_addr_c%0d", k), tr_addr[k], 1);
            chk($sformatf("stall_we_c%0d", k), tr_we[k], 0);
        end
        chk("stall_resume_addr_c10", tr_addr[10], 0);

        // Reset mid-run.
        run_op(4, 1'b0, 0, 0, 7, 0, -1);
        chk("rst_state_c8", tr_state[8], 0);
        chk("rst_busy_c8", tr_busy[8], 0);
        chk("rst_we_c8", tr_we[8], 0);
        chk("rst_in_req_c8", tr_in[8], 0);
        chk("rst_done_c8", tr_done[8], 0);
        chk("rst_addr_c8", tr_addr[8], 0);

        // Row count clamped to ROWS.
        run_op(15, 1'b0, 0, 0, 0, 0, 44);
        chk("clamp_last_write_addr", last_wr, 7);

        // Reset asserted while stall is also high.
        run_op(5, 1'b1, 5, 9, 7, 0, -1);
        chk("rst_stall_state_c8", tr_state[8], 0);
        chk("rst_stall_busy_c8", tr_busy[8], 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mul_row_sequencer.md
MUL_ROW_SEQUENCER -- requirements
Module: mul_row_sequencer

Interface
REQ-001 Parameter ROWS, default 32, SHALL set the maximum partial-product rows held in the CA_RAM (legal range 2..128).
REQ-002 Parameter ADDR_W, default $clog2(ROWS), SHALL set the CA_RAM address width.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  sampled only in IDLE; starts one multiplication.
REQ-007 n_rows  in  ADDR_W+1  row count, latched when start is accepted.
REQ-008 mode  in  1  latched with start; 0 = accumulate (re-read previous rows), 1 = bypass (no re-read).
REQ-009 stall  in  1  freezes the sequencer while high.
REQ-010 addr  out  ADDR_W  CA_RAM address.
REQ-011 we  out  1  CA_RAM write enable.
REQ-012 in_req  out  1  request for the next operand digit from the input stage.
REQ-013 row  out  ADDR_W  current row index.
REQ-014 state  out  3  current state encoding, for debug.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have six states, encoded in the package: IDLE=0, ZERO_ROW=1, WRITE_NEW=2, READ_PREV=3, CLEAR=4, DONE=5.
REQ-018 IDLE: on start=1 with n_rows!=0, the block SHALL latch n_rows, clamped to ROWS, and mode, set row=0, and go to ZERO_ROW; start with n_rows==0 SHALL be ignored.
REQ-019 ZERO_ROW: outputs SHALL be addr=0, we=1, in_req=1; next state SHALL be DONE if the latched count is 1, else WRITE_NEW with row=1.
REQ-020 WRITE_NEW: outputs SHALL be addr=row, we=1; next state SHALL be READ_PREV with addr=row-1 (mode 0), or CLEAR (mode 1).
REQ-021 READ_PREV: we SHALL be 0 and addr SHALL decrement by 1 each cycle; when addr==0, in_req SHALL be 1 and next state SHALL be CLEAR.
REQ-022 CLEAR: outputs SHALL be addr=0, we=0; in_req SHALL be 1 only in mode 1; next state SHALL be DONE if row==count-1, else WRITE_NEW with row+1.
REQ-023 DONE: done SHALL be 1 for one cycle; next state SHALL be IDLE.
REQ-024 addr, we, in_req and done SHALL be Moore decodes of registered state, with stall as the only combinational gate.
REQ-025 While stall=1, all registers SHALL hold and we, in_req and done SHALL be forced to 0; on release, the same cycle SHALL replay.
REQ-026 start, n_rows and mode SHALL be ignored while busy=1.
REQ-027 In mode 0, latency SHALL be 2 + sum over k=1..N-1 of (k+2) cycles from start acceptance to the done cycle inclusive; in mode 1 it SHALL be 2 + 2(N-1).
REQ-028 The row and addr arithmetic SHALL never wrap below 0 or above ROWS-1.

Reset
REQ-029 On rst=1, the block SHALL go to IDLE with row=0 and addr=0, and all outputs (we, in_req, busy, done) SHALL be 0, next cycle, regardless of stall.
REQ-030 Reset mid-operation SHALL abort the operation without a done pulse.

Structure
REQ-031 State encodings and the ROWS bound SHALL live in package mul_ctrl_pkg.
REQ-032 The block SHALL be a single module with no sub-modules.

Verification
REQ-033 ROWS=8, N=4, mode 0, start at cycle 0: cycles 1-14 SHALL give addr 0,1,0,0,2,1,0,0,3,2,1,0,0,0; we=1 at cycles 1, 2, 5, 9; in_req=1 at cycles 1, 3, 7, 12; done at cycle 14.
REQ-034 N=3, mode 1: states SHALL be ZERO, W1, C, W2, C, DONE; done at cycle 6; in_req=1 at cycles 1, 3, 5.
REQ-035 N=1: ZERO_ROW at cycle 1 and done at cycle 2; N=0: start ignored and busy stays 0.
REQ-036 N=4, mode 0, stall high for cycles 6-8: addr holds 1 with we=0; the sequence resumes and done moves to cycle 17.
REQ-037 rst at cycle 7 of an N=4 run: cycle 8 SHALL show IDLE with all outputs 0 and no done pulse; start at cycle 3 of a run SHALL be ignored.
REQ-038 n_rows=15 with ROWS=8: the count SHALL clamp to 8, the final WRITE_NEW SHALL have addr=7, and done SHALL arrive at cycle 44.
